// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write side of the 16-deep stereo audio sample FIFO.
// Each accepted stereo frame becomes two back-to-back FIFO word writes,
// left sample first. The block also owns the write pointer, derives
// level/full/almost-full against the read pointer, and keeps a sticky
// overflow flag plus a saturating count of dropped frames.
module fifo_write_ctrl #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_wr,
  input  logic [DATA_W-1:0] din_l,
  input  logic [DATA_W-1:0] din_r,
  input  logic [ADDR_W:0]   rptr,
  input  logic              ovf_clr,
  output logic              frame_ready,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_din,
  output logic [ADDR_W:0]   wptr,
  output logic              fifo_full,
  output logic              fifo_almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  // Pointer-width constants. DEPTH needs the extra wrap bit to be representable.
  localparam logic [ADDR_W:0] DEPTH       = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_THR   = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] FRAME_WORDS = (ADDR_W+1)'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_L = 2'd1,
    WR_R = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] hold_r;   // right sample parked while the left word goes out
  logic [ADDR_W:0]   free;
  logic              accept;
  logic              drop;

  // Occupancy from the pointer pair; follows rptr with no register delay.
  always_comb begin
    level            = wptr - rptr;
    free             = DEPTH - level;
    fifo_full        = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                       (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    fifo_almost_full = (level >= AFULL_THR);
  end

  // A frame is taken only from IDLE with room for both words; any other
  // request is lost. Space is never rechecked mid-frame because the read
  // side can only free words.
  always_comb begin
    accept = frame_wr && (state == IDLE) && (free >= FRAME_WORDS);
    drop   = frame_wr && !accept;
  end

  // Frame serialiser. Outputs are registered alongside the state so that
  // fifo_wr/fifo_din/frame_ready never depend combinationally on frame_wr.
  // The left sample is loaded straight into fifo_din, which is therefore
  // its hold register; only the right sample needs a separate one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_ready <= 1'b1;
      fifo_wr     <= 1'b0;
      fifo_din    <= '0;
      hold_r      <= '0;
      wptr        <= '0;
    end else begin
      if (fifo_wr) begin
        wptr <= wptr + 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= WR_L;
            frame_ready <= 1'b0;
            fifo_wr     <= 1'b1;
            fifo_din    <= din_l;
            hold_r      <= din_r;
          end
        end
        WR_L: begin
          state       <= WR_R;
          frame_ready <= 1'b0;
          fifo_wr     <= 1'b1;
          fifo_din    <= hold_r;
        end
        WR_R: begin
          state       <= IDLE;
          frame_ready <= 1'b1;
          fifo_wr     <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          frame_ready <= 1'b1;
          fifo_wr     <= 1'b0;
        end
      endcase
    end
  end

  // Drop bookkeeping. A drop in the same cycle as a clear restarts the
  // count at one rather than losing that drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Bench for fifo_write_ctrl: directed scenarios followed by a random phase,
// every cycle compared against a schedule-based model of the FIFO writer.
module tb_fifo_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_wr = 1'b0;
  logic [23:0] din_l = '0;
  logic [23:0] din_r = '0;
  logic [4:0]  rptr = '0;
  logic        ovf_clr = 1'b0;
  logic        frame_ready;
  logic        fifo_wr;
  logic [23:0] fifo_din;
  logic [4:0]  wptr;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Model: words scheduled for writing, the word being written this cycle,
  // the number of words written so far (mod 32) and the drop statistics.
  logic [23:0] pend[$];
  bit          m_wr;
  logic [23:0] m_din;
  int          m_wcount;
  bit          m_ovf;
  int          m_cnt;

  fifo_write_ctrl #(.DATA_W(24), .ADDR_W(4), .AFULL_LVL(12)) dut (
    .clk(clk), .rst_n(rst_n), .frame_wr(frame_wr), .din_l(din_l), .din_r(din_r),
    .rptr(rptr), .ovf_clr(ovf_clr), .frame_ready(frame_ready), .fifo_wr(fifo_wr),
    .fifo_din(fifo_din), .wptr(wptr), .fifo_full(fifo_full),
    .fifo_almost_full(fifo_almost_full), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_level();
    return (m_wcount - int'(rptr)) & 31;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_wr = 0; m_din = '0; m_wcount = 0; m_ovf = 0; m_cnt = 0;
  endtask

  // One clock edge of the model, applied to the inputs present during the cycle.
  task automatic model_edge(input bit fw, input logic [23:0] l, input logic [23:0] r, input bit clr);
    int  free;
    bit  dropped;
    free    = 16 - m_level();
    dropped = 0;
    if (m_wr) m_wcount = (m_wcount + 1) % 32;
    if (fw) begin
      if (!m_wr && pend.size() == 0 && free >= 2) begin
        pend.push_back(l);
        pend.push_back(r);
      end else begin
        dropped = 1;
      end
    end
    if (dropped) begin
      m_ovf = 1;
      m_cnt = clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_ovf = 0;
      m_cnt = 0;
    end
    if (pend.size() > 0) begin
      m_wr  = 1;
      m_din = pend.pop_front();
    end else begin
      m_wr = 0;
    end
  endtask

  task automatic check_all(input string ph);
    int lv;
    lv = m_level();
    chk({ph, ".fifo_wr"}, 32'(fifo_wr), 32'(m_wr));
    if (m_wr) chk({ph, ".fifo_din"}, 32'(fifo_din), 32'(m_din));
    chk({ph, ".frame_ready"}, 32'(frame_ready), 32'(!m_wr));
    chk({ph, ".wptr"}, 32'(wptr), 32'(m_wcount));
    chk({ph, ".level"}, 32'(level), 32'(lv));
    chk({ph, ".full"}, 32'(fifo_full), 32'(lv == 16));
    chk({ph, ".afull"}, 32'(fifo_almost_full), 32'(lv >= 12));
    chk({ph, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({ph, ".drop_cnt"}, 32'(drop_cnt), 32'(m_cnt));
  endtask

  // Drive one cycle from a negedge, let the edge happen, check on the next negedge.
  task automatic cycle(input string ph, input bit fw, input logic [23:0] l, input logic [23:0] r, input bit clr);
    frame_wr = fw; din_l = l; din_r = r; ovf_clr = clr;
    @(posedge clk);
    model_edge(fw, l, r, clr);
    @(negedge clk);
    frame_wr = 0; ovf_clr = 0;
    $display("[%0t] %s fw=%0b clr=%0b wr=%0b din=%06h wptr=%0d rptr=%0d lvl=%0d cnt=%0d",
             $time, ph, fw, clr, fifo_wr, fifo_din, wptr, rptr, level, drop_cnt);
    check_all(ph);
  endtask

  task automatic frame(input string ph, input logic [23:0] l, input logic [23:0] r);
    cycle(ph, 1, l, r, 0);
    cycle(ph, 0, 0, 0, 0);
    cycle(ph, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_reset");

    // Single frame: 0x111 then 0x222, wptr 0 -> 2
    cycle("frame1", 1, 24'h000111, 24'h000222, 0);
    chk("frame1.left", 32'(fifo_din), 32'h000111);
    cycle("frame1", 0, 0, 0, 0);
    chk("frame1.right", 32'(fifo_din), 32'h000222);
    cycle("frame1", 0, 0, 0, 0);
    chk("frame1.wptr", 32'(wptr), 32'd2);
    chk("frame1.level", 32'(level), 32'd2);

    // Seven more frames fill the FIFO (rptr held at 0)
    for (int i = 0; i < 7; i++) frame("fill", 24'(32'h100 + 2*i), 24'(32'h101 + 2*i));
    chk("fill.full", 32'(fifo_full), 32'd1);
    chk("fill.wptr", 32'(wptr), 32'h10);
    // Ninth frame is dropped
    cycle("drop9", 1, 24'hBAD000, 24'hBAD001, 0);
    chk("drop9.nowr", 32'(fifo_wr), 32'd0);
    chk("drop9.cnt", 32'(drop_cnt), 32'd1);

    // Saturate the drop counter, then clear it
    for (int i = 0; i < 260; i++) cycle("sat", 1, 24'(i), 24'(i), 0);
    chk("sat.cnt", 32'(drop_cnt), 32'd255);
    cycle("clr", 0, 0, 0, 1);
    chk("clr.cnt", 32'(drop_cnt), 32'd0);

    // Level 15: dropped. Level 14: accepted, ends at 16.
    rptr = 5'd1;
    cycle("lvl15", 1, 24'hAAAAAA, 24'hBBBBBB, 0);
    chk("lvl15.drop", 32'(drop_cnt), 32'd1);
    rptr = 5'd2;
    frame("lvl14", 24'hCCCCCC, 24'hDDDDDD);
    chk("lvl14.level", 32'(level), 32'd16);

    // Request during WR_L is dropped, the in-flight frame is unaffected
    rptr = 5'd14;
    cycle("wrl_pulse", 1, 24'h123456, 24'h654321, 0);
    cycle("wrl_pulse", 1, 24'hDEAD00, 24'hDEAD01, 0);
    chk("wrl_pulse.right", 32'(fifo_din), 32'h654321);
    cycle("wrl_pulse", 0, 0, 0, 0);
    chk("wrl_pulse.cnt", 32'(drop_cnt), 32'd2);

    // Pointer wrap 31 -> 0 with level steady at 4
    rptr = 5'd16;
    for (int i = 0; i < 10; i++) begin
      rptr = rptr + 5'd1;
      cycle("wrap", 1, 24'($urandom), 24'($urandom), 0);
      rptr = rptr + 5'd1;
      cycle("wrap", 0, 0, 0, 0);
      cycle("wrap", 0, 0, 0, 0);
      chk("wrap.level4", 32'(level), 32'd4);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (m_level() > 0 && $urandom_range(0, 2) == 0) rptr = rptr + 5'd1;
      cycle("rand", $urandom_range(0, 2) == 0, 24'($urandom), 24'($urandom),
            $urandom_range(0, 19) == 0);
    end

    // Reset during WR_R takes effect immediately
    while (m_wr) cycle("drain", 0, 0, 0, 0);
    cycle("rst_mid", 1, 24'h0F0F0F, 24'hF0F0F0, 0);
    cycle("rst_mid", 0, 0, 0, 0);
    rst_n = 1'b0;
    rptr  = 5'd0;
    #1;
    chk("rst_mid.fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst_mid.wptr", 32'(wptr), 32'd0);
    chk("rst_mid.ready", 32'(frame_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("rst_rel");

    // Drop together with ovf_clr: count restarts at one
    cycle("clrdrop", 1, 24'h1, 24'h2, 0);
    cycle("clrdrop", 1, 24'h3, 24'h4, 0);
    cycle("clrdrop", 1, 24'h5, 24'h6, 0);
    chk("clrdrop.pre", 32'(drop_cnt), 32'd2);
    cycle("clrdrop", 1, 24'h7, 24'h8, 0);
    cycle("clrdrop", 1, 24'h9, 24'hA, 1);
    chk("clrdrop.cnt", 32'(drop_cnt), 32'd1);
    chk("clrdrop.ovf", 32'(overflow), 32'd1);
    cycle("clrdrop", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_write_ctrl.md
# fifo_write_ctrl

Write-side controller for the 16-deep audio sample FIFO. It accepts stereo frames (left + right sample) from the capture path and serialises each frame into two consecutive FIFO word writes. It maintains the write pointer and computes full, almost-full and level against the read pointer returned by the FIFO read side. It also reports dropped frames. Both sides of the FIFO run on the same `clk`.

## Interface
Parameters:
- `DATA_W`, 24, sample width in bits.
- `ADDR_W`, 4, FIFO address width. Depth is 2^ADDR_W; pointers are ADDR_W+1 bits and include a wrap bit.
- `AFULL_LVL`, 12, level at or above which `fifo_almost_full` asserts.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `frame_wr`  in  1  one-cycle request to store a stereo frame.
- `din_l`  in  DATA_W  left sample, sampled when `frame_wr` is high.
- `din_r`  in  DATA_W  right sample, sampled when `frame_wr` is high.
- `rptr`  in  ADDR_W+1  read pointer from the FIFO read side.
- `ovf_clr`  in  1  clears `overflow` and `drop_cnt`.
- `frame_ready`  out  1  high when a frame request can be accepted.
- `fifo_wr`  out  1  FIFO write strobe.
- `fifo_din`  out  DATA_W  FIFO write data.
- `wptr`  out  ADDR_W+1  write pointer.
- `fifo_full`  out  1  FIFO full flag.
- `fifo_almost_full`  out  1  level >= AFULL_LVL.
- `level`  out  ADDR_W+1  number of words currently held.
- `overflow`  out  1  sticky flag, set on any dropped frame.
- `drop_cnt`  out  8  saturating count of dropped frames.

## Operation
- Pointer arithmetic:
  - `level = (wptr - rptr) mod 2^(ADDR_W+1)`.
  - `fifo_full = (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0])`.
  - `free = 2^ADDR_W - level`.
  - These three are combinational from the current registers and `rptr`.
- FSM states:
  - IDLE: `frame_ready`=1, `fifo_wr`=0.
  - WR_L: `fifo_wr`=1, `fifo_din`=held left sample.
  - WR_R: `fifo_wr`=1, `fifo_din`=held right sample.
- Transitions:
  - IDLE → WR_L when `frame_wr` && `free` >= 2. The frame is accepted and `din_l`/`din_r` are latched into hold registers.
  - IDLE stays IDLE when `frame_wr` && `free` < 2. The frame is dropped.
  - WR_L → WR_R unconditionally.
  - WR_R → IDLE unconditionally.
- `wptr` increments by 1 at the end of every cycle in which `fifo_wr`=1. It wraps from 2^(ADDR_W+1)-1 to 0.
- A frame is either written whole or not at all. Space is checked only at acceptance. The read side can only free space, so WR_L and WR_R never hit full.
- Drops: `frame_wr` in WR_L or WR_R is a drop, as is `frame_wr` in IDLE with `free` < 2.
  - On a drop, `overflow` is set to 1.
  - On a drop, `drop_cnt` increments and saturates at 255.
- `ovf_clr`:
  - Clears `overflow` and `drop_cnt` to 0 on the next edge.
  - If a drop occurs in the same cycle as `ovf_clr`, the drop wins: `overflow`=1 and `drop_cnt`=1.
- Reset values:
  - FSM = IDLE, `wptr`=0.
  - `fifo_wr`=0, `fifo_din`=0, hold registers = 0.
  - `overflow`=0, `drop_cnt`=0.
  - With `rptr`=0: `level`=0, `fifo_full`=0, `fifo_almost_full`=0.
- Reset asserted mid-frame aborts the frame immediately. A half-written frame can be left in the FIFO memory; the read side is reset by the same `rst_n`, so both pointers return to 0.

## Timing
- `fifo_wr`, `fifo_din` and `frame_ready` are register outputs; they have no combinational path from `frame_wr`.
- Write latency:
  - `frame_wr` accepted at edge t.
  - Left word written in cycle t+1.
  - Right word written in cycle t+2.
  - `frame_ready` returns in cycle t+3.
- Maximum throughput is one frame per 3 clocks.
- `level` reflects a write one cycle after the strobe cycle, because `wptr` updates at the edge ending that cycle.
- `level` reflects a read as soon as `rptr` changes.

## Test plan
- Reset, then one frame with `din_l`=0x000111 and `din_r`=0x000222. Expect `fifo_wr` high for 2 cycles with `fifo_din` 0x000111 then 0x000222, `wptr` 0→2, `level`=2.
- Write 8 frames with `rptr` held at 0. Expect `fifo_almost_full` to rise when `level` reaches 12 and `fifo_full`=1 at `level`=16 (`wptr`=16, binary 10000). The 9th frame is dropped: `overflow`=1, `drop_cnt`=1, no `fifo_wr`.
- With `level`=15 and `rptr` static, one frame → dropped. Then advance `rptr` by 1 (`level`=14), one frame → accepted, `level`=16.
- Pulse `frame_wr` in WR_L. Expect `drop_cnt`+1 and the in-flight frame completes unchanged.
- Move `wptr` and `rptr` through 31→0 wrap with `level` steady at 4. Expect `level`=4 and no false `fifo_full`.
- Assert `rst_n` low during WR_R. Expect `fifo_wr`=0, `wptr`=0 and the FSM in IDLE immediately. Assert `ovf_clr` together with a drop; expect `drop_cnt`=1.
